// File: rtl/risc_mem_arbiter.sv
// Round-robin arbiter sharing a single-port memory between the CPU and a debug/loader port.
// Optional `RISC_ARB_DBG_LOCK_EN adds a dbg_lock input that lets the debug port hold priority.
module risc_mem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef RISC_ARB_DBG_LOCK_EN
    input  logic          dbg_lock,
`endif
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t     state;
    owner_t     owner;
    owner_t     last_owner;
    logic [1:0] wait_cnt;
    logic       lock;
    logic       grant_dbg;

`ifdef RISC_ARB_DBG_LOCK_EN
    assign lock = dbg_lock;
`else
    assign lock = 1'b0;
`endif

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        grant_dbg = 1'b0;
        if (dbg_req && (lock || !cpu_req || last_owner == OWN_CPU))
            grant_dbg = 1'b1;
    end

    // mem_addr/mem_wdata double as the latched request; all outputs are registered with the state.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DBG;
            wait_cnt   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        owner     <= grant_dbg ? OWN_DBG : OWN_CPU;
                        mem_we    <= grant_dbg ? dbg_we    : cpu_we;
                        mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
                        mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    wait_cnt <= '0;
                    if (mem_we) begin
                        cpu_ack <= (owner == OWN_CPU);
                        dbg_ack <= (owner == OWN_DBG);
                        state   <= ACK;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (owner == OWN_CPU) begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end else begin
                            dbg_rdata <= mem_rdata;
                            dbg_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ACK: begin
                    last_owner <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Scoreboard bench for risc_mem_arbiter: a RD_LAT=1 instance checked by a monitor process,
// plus a RD_LAT=3 instance for latency; the dbg_lock test runs when RISC_ARB_DBG_LOCK_EN is set.
module tb_risc_mem_arbiter;

    localparam int RD_LAT1  = 1;
    localparam int MAX_WAIT = 60;

    typedef struct {
        bit         dbg;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // main instance signals
    logic       dbg_lock;
    logic       cpu_req, cpu_we, cpu_ack, dbg_req, dbg_we, dbg_ack;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
    logic       mem_en, mem_we, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    // RD_LAT=3 instance signals (CPU port only)
    logic       cpu_req3, cpu_ack3, dbg_ack3;
    logic [7:0] cpu_addr3, cpu_rdata3, dbg_rdata3;
    logic       mem_en3, mem_we3, busy3;
    logic [7:0] mem_addr3, mem_wdata3, mem_rdata3;

    risc_mem_arbiter #(.AW(8), .DW(8), .RD_LAT(RD_LAT1)) u_dut (
        .clk(clk), .rst_n(rst_n),
`ifdef RISC_ARB_DBG_LOCK_EN
        .dbg_lock(dbg_lock),
`endif
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    risc_mem_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
`ifdef RISC_ARB_DBG_LOCK_EN
        .dbg_lock(1'b0),
`endif
        .cpu_req(cpu_req3), .cpu_we(1'b0), .cpu_addr(cpu_addr3), .cpu_wdata(8'h00),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(8'h00), .dbg_wdata(8'h00),
        .dbg_ack(dbg_ack3), .dbg_rdata(dbg_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    function automatic logic [7:0] init_val(input int a);
        case (a)
            8'h00:   return 8'hBF;
            8'h10:   return 8'h11;
            8'h20:   return 8'h22;
            8'h40:   return 8'h44;
            8'hFF:   return 8'h2A;
            default: return 8'h5A;
        endcase
    endfunction

    // Memory models: preloaded on the first edge, synchronous reads with RD_LAT-deep pipelines.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic       loaded = 1'b0;
    logic [7:0] rd1, p0, p1, p2;
    assign mem_rdata  = rd1;
    assign mem_rdata3 = p2;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= init_val(i);
                mem3[i] <= init_val(i);
            end
            loaded <= 1'b1;
        end else begin
            if (mem_en) begin
                if (mem_we) mem1[mem_addr] <= mem_wdata;
                else        rd1 <= mem1[mem_addr];
            end
            if (mem_en3) begin
                if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
                else         p0 <= mem3[mem_addr3];
            end
            p1 <= p0;
            p2 <= p1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: checks each memory strobe and each ack against the head of the scoreboard.
    int   en_cnt    = 0;
    int   issue_cyc = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt = 0;
        end else begin
            if (mem_en) begin
                en_cnt++;
                issue_cyc = cyc;
                if (sb.size() == 0) fail_now("unexpected_mem_en");
                else begin
                    check("issue_we", mem_we, sb[0].we);
                    check("issue_addr", mem_addr, sb[0].addr);
                    if (sb[0].we) check("issue_wdata", mem_wdata, sb[0].wdata);
                end
            end
            if (cpu_ack || dbg_ack) begin
                check("ack_exclusive", cpu_ack && dbg_ack, 0);
                if (sb.size() == 0) fail_now("unexpected_ack");
                else begin
                    mon_e = sb.pop_front();
                    check("ack_port", dbg_ack, mon_e.dbg);
                    check("ack_latency", cyc - issue_cyc, mon_e.we ? 1 : 1 + RD_LAT1);
                    if (!mon_e.we) check("ack_rdata", mon_e.dbg ? dbg_rdata : cpu_rdata, mon_e.rdata);
                    check("mem_en_per_txn", en_cnt, 1);
                end
                en_cnt = 0;
            end
        end
    end

    task automatic push(input bit dbg, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rdata);
        exp_t e;
        e.dbg = dbg; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic cpu_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        int n = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        do begin @(negedge clk); n++; end while (!cpu_ack && n < MAX_WAIT);
        if (!cpu_ack) fail_now("cpu_ack_timeout");
        cpu_req = 1'b0;
    endtask

    task automatic dbg_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        int n = 0;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        do begin @(negedge clk); n++; end while (!dbg_ack && n < MAX_WAIT);
        if (!dbg_ack) fail_now("dbg_ack_timeout");
        dbg_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n, acks, busy_cnt, iss3, ack3, dbg3;
        rst_n = 1'b0; dbg_lock = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
        cpu_req3 = 1'b0; cpu_addr3 = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_dbg_ack", dbg_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU read of 0x00 holding 0xBF
        push(0, 0, 8'h00, 8'h00, 8'hBF);
        cpu_txn(1'b0, 8'h00, 8'h00);

        // Debug write 0x06 to 0xFE, then CPU reads it back
        push(1, 1, 8'hFE, 8'h06, 8'h00);
        dbg_txn(1'b1, 8'hFE, 8'h06);
        push(0, 0, 8'hFE, 8'h00, 8'h06);
        cpu_txn(1'b0, 8'hFE, 8'h00);
        repeat (3) @(negedge clk);
        check("cpu_rdata_hold", cpu_rdata, 8'h06);
        check("dbg_rdata_after_write", dbg_rdata, 8'h00);

        // Both ports requesting from reset: CPU, DBG, CPU, DBG
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 0, 8'h10, 8'h00, 8'h11);
        push(1, 0, 8'h20, 8'h00, 8'h22);
        push(0, 1, 8'h30, 8'h33, 8'h00);
        push(1, 0, 8'h30, 8'h00, 8'h33);
        fork
            begin cpu_txn(1'b0, 8'h10, 8'h00); cpu_txn(1'b1, 8'h30, 8'h33); end
            begin dbg_txn(1'b0, 8'h20, 8'h00); dbg_txn(1'b0, 8'h30, 8'h00); end
        join
        repeat (2) @(negedge clk);
        check("cpu_rdata_unchanged_by_write", cpu_rdata, 8'h11);
        check("dbg_rdata_last_read", dbg_rdata, 8'h33);
        check("rr_queue_drained", sb.size(), 0);

        // Reset during WAIT of a CPU read aborts it silently
        push(0, 0, 8'h40, 8'h00, 8'h44);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_en && n < MAX_WAIT);
        if (!mem_en) fail_now("abort_issue_timeout");
        @(negedge clk);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_mem_en", mem_en, 0);
        check("abort_cpu_ack", cpu_ack, 0);
        check("abort_cpu_rdata", cpu_rdata, 0);
        void'(sb.pop_front());
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) acks++;
        end
        check("abort_no_ack", acks, 0);

        // RD_LAT=3 read of 0xFF holding 0x2A
        cpu_req3 = 1'b1; cpu_addr3 = 8'hFF;
        busy_cnt = 0; iss3 = -1; ack3 = -1; dbg3 = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy3) busy_cnt++;
            if (mem_en3) iss3 = cyc;
            if (dbg_ack3) dbg3++;
            if (cpu_ack3) begin
                ack3 = cyc;
                check("lat3_rdata", cpu_rdata3, 8'h2A);
                cpu_req3 = 1'b0;
            end
        end
        if (ack3 < 0) fail_now("lat3_ack_timeout");
        else check("lat3_ack_latency", ack3 - iss3, 4);
        check("lat3_busy_cycles", busy_cnt, 5);
        check("lat3_no_dbg_ack", dbg3, 0);

`ifdef RISC_ARB_DBG_LOCK_EN
        // Debug lock: four debug writes back to back, then the CPU, then debug again
        dbg_lock = 1'b1;
        push(1, 1, 8'h50, 8'hA0, 8'h00);
        push(1, 1, 8'h51, 8'hA1, 8'h00);
        push(1, 1, 8'h52, 8'hA2, 8'h00);
        push(1, 1, 8'h53, 8'hA3, 8'h00);
        push(0, 0, 8'h50, 8'h00, 8'hA0);
        push(1, 0, 8'h51, 8'h00, 8'hA1);
        fork
            cpu_txn(1'b0, 8'h50, 8'h00);
            begin
                dbg_txn(1'b1, 8'h50, 8'hA0);
                dbg_txn(1'b1, 8'h51, 8'hA1);
                dbg_txn(1'b1, 8'h52, 8'hA2);
                dbg_txn(1'b1, 8'h53, 8'hA3);
                dbg_lock = 1'b0;
                dbg_txn(1'b0, 8'h51, 8'h00);
            end
        join
        repeat (2) @(negedge clk);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_mem_arbiter.md
Name: risc_mem_arbiter

Overview:
Shares the single-port 256x8 RISC memory between two requesters: the CPU port (instruction fetch, LOAD, STORE) and a debug/loader port (program load, result readback such as m[FF]). The CPU becomes multi-cycle: it raises a request and stalls until it receives an ack. A small FSM sequences each access, and round-robin arbitration prevents either port from starving the other.

Parameters:
AW, 8, address width (256-entry memory)
DW, 8, data width
RD_LAT, 1, memory read latency in cycles (legal range 1..3)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  reset; synchronous, active-low
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  registered read data; valid when cpu_ack=1
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the cpu_* group, for the debug port
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data; valid RD_LAT cycles after mem_en
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values: state=IDLE, all outputs 0, cpu_rdata/dbg_rdata=0, last_owner=DBG (so the CPU wins the first tie).
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Sample both requests.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port != last_owner.
  - On grant: latch owner, we, addr, wdata into internal registers; go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we=latched we; mem_addr/mem_wdata from the latched values.
  - Write: go to ACK. Read: go to WAIT.
- WAIT (exactly RD_LAT cycles):
  - mem_en=0.
  - On the last WAIT cycle, capture mem_rdata into the owner's rdata register; go to ACK.
- ACK (1 cycle):
  - owner's ack=1; last_owner<=owner; go to IDLE.
  - Requests are ignored in this cycle.
- Latency, counted from the ISSUE cycle N:
  - Write ack at cycle N+1.
  - Read ack at cycle N+1+RD_LAT.
  - Minimum request-to-request turnaround: write 3 cycles, read 3+RD_LAT cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until ack.
  - Drop req, or present a new request, in the cycle after ack.
  - The arbiter latches its inputs in IDLE, so changes after the grant do not affect the access in flight.
- rdata outputs hold their value until the next read completion on the same port. Writes do not modify rdata.
- The non-owner's ack stays 0 throughout a transaction.
- Both acks are never high in the same cycle.
- mem_en is high for exactly one cycle per transaction.
- A request that arrives while busy waits in the requester's hold; no queue.
- Reset mid-operation:
  - The next edge with rst_n=0 forces IDLE and clears the outputs.
  - A write whose ISSUE edge has already occurred stays committed in memory.
  - No ack is ever produced for an aborted transaction.
- Addresses wrap naturally at AW bits; no range checking.

Optional Feature:
RISC_ARB_DBG_LOCK_EN
- Defined:
  - Adds input port dbg_lock (1 bit).
  - While dbg_lock=1 and dbg_req=1 in IDLE, debug is granted regardless of last_owner, so the CPU stalls for back-to-back debug bursts (program load).
  - Debug lock has priority over a pending cpu_req.
  - When dbg_lock drops, round-robin resumes using the last_owner value.
- Not defined: no dbg_lock port; strict round-robin only.

Test Plan:
- Reset release, CPU read of addr 0x00 with memory=0xBF, RD_LAT=1 -> mem_en pulse at cycle N, cpu_ack at N+2, cpu_rdata=0xBF; dbg_ack stays 0.
- Debug write 0x06 to 0xFE, then CPU read of 0xFE -> write ack at N+1; CPU read returns 0x06; exactly one mem_en per transaction.
- cpu_req and dbg_req both high continuously from reset -> grants alternate CPU, DBG, CPU, DBG; no two consecutive acks to the same port.
- rst_n=0 asserted during WAIT of a CPU read -> next cycle state=IDLE, mem_en=0, cpu_ack never pulses, cpu_rdata=0.
- RD_LAT=3 read of 0xFF holding 0x2A -> cpu_ack at N+4 with 0x2A; busy high for exactly 5 cycles.
- RISC_ARB_DBG_LOCK_EN defined, dbg_lock=1, both requests high for 4 debug transactions -> 4 consecutive dbg_acks, no cpu_ack; after dbg_lock drops, the next grant goes to the CPU.
